// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one external combinational 4-bit ALU between two requesters.
// A round-robin arbiter picks one pending request while idle, registers that
// requester's op/operands onto the ALU bus, and holds them for LAT cycles.
// It then captures the ALU answer into the winner's result register and
// pulses that requester's done strobe for one cycle.
//
// The block never decodes the op code and never modifies alu_ans.
// Arithmetic, width handling and wrap-around all belong to the external ALU.
//
// Parameters
//   LAT         cycles the ALU operands are held before alu_ans is sampled
//               (legal range 1..15)
//   FIRST_PRIO  requester that wins the first tie after reset (0 or 1)
//
// Ports
//   clk                      rising-edge clock
//   reset                    synchronous, active-high reset
//   req0/op0/a0/b0/c0        requester 0: request, op code, operands, shift
//   req1/op1/a1/b1/c1        requester 1: same fields
//   gnt0, gnt1               one-cycle pulse: request accepted
//   done0, done1             one-cycle pulse: matching res holds a new result
//   res0, res1               last result per requester; holds until overwritten
//   busy                     high while an operation is executing
//   alu_op/alu_a/alu_b/alu_c registered operation presented to the ALU
//   alu_ans                  ALU result, sampled on the last EXEC edge
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int unsigned LAT        = 1,
    parameter bit          FIRST_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       reset,

    input  logic       req0,
    input  logic [1:0] op0,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [1:0] c0,

    input  logic       req1,
    input  logic [1:0] op1,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    input  logic [1:0] c1,

    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [3:0] res0,
    output logic [3:0] res1,
    output logic       busy,

    output logic [1:0] alu_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_c,
    input  logic [3:0] alu_ans
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    // The counter is loaded with LAT-1 at grant time. The EXEC edge that sees
    // zero is the LAT-th edge after the grant edge, so that edge samples alu_ans.
    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       owner_q, owner_d;   // requester that owns the running op
    logic       last_q, last_d;     // winner of the most recently completed op
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic       done0_q, done0_d;
    logic       done1_q, done1_d;
    logic [3:0] res0_q, res0_d;
    logic [3:0] res1_q, res1_d;
    logic [1:0] alu_op_q, alu_op_d;
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    logic [1:0] alu_c_q, alu_c_d;

    logic       any_req;
    logic       pick;

    assign any_req = req0 | req1;

    // A sole requester always wins. On a tie, the requester that did not win
    // last time is picked. last_q updates only when an op completes, so an op
    // abandoned by reset does not move the round-robin pointer.
    assign pick = (req0 && req1) ? ~last_q : req1;

    // -------------------------------------------------------------------------
    // State register (all flops)
    // -------------------------------------------------------------------------
    // NOTE: reset is sampled only on the clock edge and overrides every other
    // update in that edge. Every flop, including the result registers, gets a
    // defined reset value. All state uses non-blocking assignments so that
    // every flop sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            owner_q  <= 1'b0;
            last_q   <= ~FIRST_PRIO;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            res0_q   <= 4'd0;
            res1_q   <= 4'd0;
            alu_op_q <= 2'd0;
            alu_a_q  <= 4'd0;
            alu_b_q  <= 4'd0;
            alu_c_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            res0_q   <= res0_d;
            res1_q   <= res1_d;
            alu_op_q <= alu_op_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_c_q  <= alu_c_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req)         state_d = EXEC;
            EXEC:    if (cnt_q == 4'd0)   state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / datapath next values
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a default at the top. Any path that skips an
    // assignment then holds or clears the value instead of inferring a latch.
    // The grant and done strobes default to 0, which makes them one-cycle pulses.
    always_comb begin
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        last_d   = last_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        res0_d   = res0_q;
        res1_d   = res1_q;
        alu_op_d = alu_op_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_c_d  = alu_c_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = pick;
                    cnt_d   = CNT_INIT;
                    if (pick) begin
                        gnt1_d   = 1'b1;
                        alu_op_d = op1;
                        alu_a_d  = a1;
                        alu_b_d  = b1;
                        alu_c_d  = c1;
                    end else begin
                        gnt0_d   = 1'b1;
                        alu_op_d = op0;
                        alu_a_d  = a0;
                        alu_b_d  = b0;
                        alu_c_d  = c0;
                    end
                end
            end

            EXEC: begin
                // The ALU bus is left untouched here, so operands stay stable
                // for the whole settle window. Requests are not looked at.
                if (cnt_q == 4'd0) begin
                    last_d = owner_q;
                    if (owner_q) begin
                        res1_d  = alu_ans;
                        done1_d = 1'b1;
                    end else begin
                        res0_d  = alu_ans;
                        done0_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Port drive
    // -------------------------------------------------------------------------
    assign gnt0   = gnt0_q;
    assign gnt1   = gnt1_q;
    assign done0  = done0_q;
    assign done1  = done1_q;
    assign res0   = res0_q;
    assign res1   = res1_q;
    assign busy   = (state_q == EXEC);
    assign alu_op = alu_op_q;
    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_c  = alu_c_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Two arbiter instances share the same requester stimulus:
//   d1: LAT=1, FIRST_PRIO=0
//   d3: LAT=3, FIRST_PRIO=1
// Each instance drives its own behavioural 4-bit ALU.
//
// Expected results go onto a per-instance queue at grant time. They are popped
// and compared when the done pulse appears. The single-requester cases come
// from a vector table. Round-robin, long latency and reset during EXEC use
// hand-written sequences.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [1:0] op0, op1, c0, c1;
    logic [3:0] a0, b0, a1, b1;

    logic       d1_gnt0, d1_gnt1, d1_done0, d1_done1, d1_busy;
    logic [3:0] d1_res0, d1_res1, d1_alu_a, d1_alu_b, d1_ans;
    logic [1:0] d1_alu_op, d1_alu_c;

    logic       d3_gnt0, d3_gnt1, d3_done0, d3_done1, d3_busy;
    logic [3:0] d3_res0, d3_res1, d3_alu_a, d3_alu_b, d3_ans;
    logic [1:0] d3_alu_op, d3_alu_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Stand-in for the external ALU that sits outside the arbiter.
    function automatic logic [3:0] alu_model(input logic [1:0] op, input logic [3:0] a,
                                             input logic [3:0] b, input logic [1:0] c);
        logic signed [3:0] sa;
        sa = a;
        case (op)
            2'b00:   return 4'(sa >>> c);
            2'b01:   return a >> c;
            2'b10:   return a - b;
            default: return a + b;
        endcase
    endfunction

    assign d1_ans = alu_model(d1_alu_op, d1_alu_a, d1_alu_b, d1_alu_c);
    assign d3_ans = alu_model(d3_alu_op, d3_alu_a, d3_alu_b, d3_alu_c);

    alu_share_arbiter #(.LAT(1), .FIRST_PRIO(1'b0)) dut1 (
        .clk(clk), .reset(reset),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0), .c0(c0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1), .c1(c1),
        .gnt0(d1_gnt0), .gnt1(d1_gnt1), .done0(d1_done0), .done1(d1_done1),
        .res0(d1_res0), .res1(d1_res1), .busy(d1_busy),
        .alu_op(d1_alu_op), .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_c(d1_alu_c),
        .alu_ans(d1_ans)
    );

    alu_share_arbiter #(.LAT(3), .FIRST_PRIO(1'b1)) dut3 (
        .clk(clk), .reset(reset),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0), .c0(c0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1), .c1(c1),
        .gnt0(d3_gnt0), .gnt1(d3_gnt1), .done0(d3_done0), .done1(d3_done1),
        .res0(d3_res0), .res1(d3_res1), .busy(d3_busy),
        .alu_op(d3_alu_op), .alu_a(d3_alu_a), .alu_b(d3_alu_b), .alu_c(d3_alu_c),
        .alu_ans(d3_ans)
    );

    typedef struct {
        logic       who;
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] c;
        logic [3:0] exp;
    } vec_t;

    typedef struct {
        logic       who;
        logic [3:0] res;
    } sb_t;

    sb_t        sb1[$];
    logic [3:0] exp1_r0, exp1_r1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one rising edge, then settle, so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0 = 1'b0; req1 = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        exp1_r0 = 4'd0;
        exp1_r1 = 4'd0;
        sb1.delete();
    endtask

    // If d1 shows a done pulse this cycle, pop the scoreboard and compare against it.
    task automatic check_done1();
        sb_t e;
        if (d1_done0 || d1_done1) begin
            check("d1 done onehot", {d1_done1, d1_done0} != 2'b11, 1);
            check("d1 scoreboard nonempty", sb1.size() != 0, 1);
            if (sb1.size() != 0) begin
                e = sb1.pop_front();
                check("d1 done who", {d1_done1, d1_done0}, e.who ? 2'b10 : 2'b01);
                if (e.who) exp1_r1 = e.res;
                else       exp1_r0 = e.res;
                check("d1 res0", d1_res0, exp1_r0);
                check("d1 res1", d1_res1, exp1_r1);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        vec_t vecs[10];
        int   n, nb, ngnt, last_cyc, n0, n1;

        vecs[0] = '{1'b0, 2'b11, 4'd3,     4'd4,  2'd0, 4'd7};
        vecs[1] = '{1'b1, 2'b00, 4'b1000,  4'd0,  2'd2, 4'b1110};
        vecs[2] = '{1'b1, 2'b01, 4'b1000,  4'd0,  2'd2, 4'b0010};
        vecs[3] = '{1'b0, 2'b10, 4'd2,     4'd5,  2'd0, 4'b1101};
        vecs[4] = '{1'b0, 2'b00, 4'd7,     4'd9,  2'd3, 4'd0};
        vecs[5] = '{1'b1, 2'b11, 4'd15,    4'd15, 2'd1, 4'd14};
        vecs[6] = '{1'b0, 2'b01, 4'd15,    4'd6,  2'd0, 4'd15};
        vecs[7] = '{1'b1, 2'b10, 4'd0,     4'd1,  2'd3, 4'd15};
        vecs[8] = '{1'b0, 2'b00, 4'b1011,  4'd2,  2'd1, 4'b1101};
        vecs[9] = '{1'b1, 2'b00, 4'b1001,  4'd5,  2'd3, 4'b1111};

        op0 = 2'd0; a0 = 4'd0; b0 = 4'd0; c0 = 2'd0;
        op1 = 2'd0; a1 = 4'd0; b1 = 4'd0; c1 = 2'd0;
        do_reset();

        // ---------------- reset state ----------------
        check("d1 reset strobes", {d1_gnt0, d1_gnt1, d1_done0, d1_done1, d1_busy}, 5'd0);
        check("d1 reset res", {d1_res0, d1_res1}, 8'd0);
        check("d1 reset alu bus", {d1_alu_op, d1_alu_a, d1_alu_b, d1_alu_c}, 12'd0);
        check("d3 reset strobes", {d3_gnt0, d3_gnt1, d3_done0, d3_done1, d3_busy}, 5'd0);
        check("d3 reset res+bus", {d3_res0, d3_res1, d3_alu_op, d3_alu_a, d3_alu_b, d3_alu_c}, 20'd0);

        // ---------------- table-driven single requests on d1 (LAT=1) ----------------
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].who) begin
                req1 = 1'b1; op1 = vecs[i].op; a1 = vecs[i].a; b1 = vecs[i].b; c1 = vecs[i].c;
            end else begin
                req0 = 1'b1; op0 = vecs[i].op; a0 = vecs[i].a; b0 = vecs[i].b; c0 = vecs[i].c;
            end
            step();
            check($sformatf("v%0d gnt", i), {d1_gnt1, d1_gnt0}, vecs[i].who ? 2'b10 : 2'b01);
            check($sformatf("v%0d busy at gnt", i), d1_busy, 1);
            check($sformatf("v%0d alu bus", i), {d1_alu_op, d1_alu_a, d1_alu_b, d1_alu_c},
                  {vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c});
            sb1.push_back('{vecs[i].who, vecs[i].exp});
            req0 = 1'b0; req1 = 1'b0;
            n = 0;
            do begin
                step();
                n++;
            end while (!(d1_done0 || d1_done1) && n < 20);
            check($sformatf("v%0d latency", i), n, 1);
            check($sformatf("v%0d idle in done cycle", i), {d1_busy, d1_gnt0, d1_gnt1}, 3'b000);
            check_done1();
        end
        check("d1 scoreboard drained", sb1.size(), 0);

        // ---------------- round robin, both requesting, d1 ----------------
        do_reset();
        op0 = 2'b11; a0 = 4'd1; b0 = 4'd2; c0 = 2'd0;
        op1 = 2'b10; a1 = 4'd1; b1 = 4'd3; c1 = 2'd0;
        req0 = 1'b1; req1 = 1'b1;
        ngnt = 0; last_cyc = 0; n0 = 0; n1 = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            step();
            // A requester that dropped in its gnt cycle re-raises one cycle later.
            req0 = (n0 < 2);
            req1 = (n1 < 2);
            if (d1_done0 || d1_done1) check("rr busy low in done cycle", d1_busy, 0);
            check_done1();
            if (d1_gnt0 || d1_gnt1) begin
                check("rr gnt onehot", {d1_gnt1, d1_gnt0} != 2'b11, 1);
                check($sformatf("rr order %0d", ngnt), {d1_gnt1, d1_gnt0},
                      (ngnt % 2 == 1) ? 2'b10 : 2'b01);
                check("rr busy at gnt", d1_busy, 1);
                if (ngnt > 0) check($sformatf("rr spacing %0d", ngnt), cyc - last_cyc, 2);
                if (d1_gnt1) begin
                    sb1.push_back('{1'b1, 4'(a1 - b1)});
                    a1 = a1 + 4'd4;
                    req1 = 1'b0;
                    n1++;
                end else begin
                    sb1.push_back('{1'b0, 4'(a0 + b0)});
                    a0 = a0 + 4'd1;
                    req0 = 1'b0;
                    n0++;
                end
                ngnt++;
                last_cyc = cyc;
            end
            if (ngnt >= 4 && sb1.size() == 0) break;
        end
        check("rr grant count", ngnt, 4);
        check("rr scoreboard drained", sb1.size(), 0);
        req0 = 1'b0; req1 = 1'b0;

        // ---------------- LAT=3 on d3 ----------------
        do_reset();
        step();
        op0 = 2'b11; a0 = 4'd15; b0 = 4'd1; c0 = 2'd0;
        req0 = 1'b1;
        step();
        check("d3 gnt0", {d3_gnt1, d3_gnt0}, 2'b01);
        req0 = 1'b0;
        a0 = 4'd3;   // operands may change after grant; the ALU bus must not follow
        n = 0; nb = 0;
        for (int k = 0; k < 20; k++) begin
            if (d3_busy) begin
                nb++;
                check("d3 alu_a held", d3_alu_a, 4'd15);
            end
            if (d3_done0 || d3_done1) break;
            step();
            n++;
        end
        check("d3 latency", n, 3);
        check("d3 busy cycles", nb, 3);
        check("d3 done who", {d3_done1, d3_done0}, 2'b01);
        check("d3 res0 wrap", d3_res0, 4'd0);
        check("d3 res1 untouched", d3_res1, 4'd0);

        // A completed op on requester 1, so the reset below has a result to clear.
        op1 = 2'b11; a1 = 4'd2; b1 = 4'd3; c1 = 2'd0;
        req1 = 1'b1;
        step();
        check("d3 gnt1", {d3_gnt1, d3_gnt0}, 2'b10);
        req1 = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (!(d3_done0 || d3_done1) && n < 20);
        check("d3 op2 latency", n, 3);
        check("d3 op2 done who", {d3_done1, d3_done0}, 2'b10);
        check("d3 res1", d3_res1, 4'd5);

        // ---------------- reset on the second EXEC cycle ----------------
        op0 = 2'b11; a0 = 4'd1; b0 = 4'd1;
        req0 = 1'b1;
        step();                       // first EXEC cycle
        check("d3 mid gnt0", {d3_gnt1, d3_gnt0}, 2'b01);
        req0 = 1'b0;
        step();                       // second EXEC cycle
        check("d3 mid still busy", d3_busy, 1);
        reset = 1'b1;
        step();
        check("d3 mid reset strobes", {d3_gnt0, d3_gnt1, d3_done0, d3_done1, d3_busy}, 5'd0);
        check("d3 mid reset res+bus", {d3_res0, d3_res1, d3_alu_op, d3_alu_a, d3_alu_b, d3_alu_c}, 20'd0);
        reset = 1'b0;
        exp1_r0 = 4'd0; exp1_r1 = 4'd0; sb1.delete();
        n = 0;
        for (int k = 0; k < 4; k++) begin
            if (d3_done0 || d3_done1) n++;
            step();
        end
        check("d3 no done after abandon", n, 0);

        // First tie after reset goes to FIRST_PRIO on each instance.
        req0 = 1'b1; req1 = 1'b1;
        step();
        check("d3 tie after reset", {d3_gnt1, d3_gnt0}, 2'b10);
        check("d1 tie after reset", {d1_gnt1, d1_gnt0}, 2'b01);
        req0 = 1'b0; req1 = 1'b0;
        for (int k = 0; k < 6; k++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 4-bit ALU between two requesters.
- Op encoding: 00 = arithmetic right shift of A by C; 01 = logical right shift of A by C; 10 = A-B; 11 = A+B.
- Round-robin arbitration, registered operand issue to the ALU, programmable settle time, then a captured result with a one-cycle done pulse to the winning requester.
- Sits between issuing units and the ALU instance; the ALU itself stays outside this block.

Parameters:
- LAT, 1, cycles ALU operands are held before alu_ans is sampled (legal range 1..15).
- FIRST_PRIO, 0, requester that wins the first tie after reset (0 or 1).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 request.
- op0  input  2  requester 0 operation code.
- a0  input  4  requester 0 operand A.
- b0  input  4  requester 0 operand B.
- c0  input  2  requester 0 shift amount.
- req1, op1, a1, b1, c1  input  1/2/4/4/2  same fields for requester 1.
- gnt0  output  1  one-cycle pulse: requester 0 request accepted.
- gnt1  output  1  one-cycle pulse: requester 1 request accepted.
- done0  output  1  one-cycle pulse: res0 valid with new result.
- done1  output  1  one-cycle pulse: res1 valid with new result.
- res0  output  4  last result for requester 0; holds until overwritten.
- res1  output  4  last result for requester 1; holds until overwritten.
- busy  output  1  high while in EXEC.
- alu_op  output  2  registered op to ALU.
- alu_a  output  4  registered operand A to ALU.
- alu_b  output  4  registered operand B to ALU.
- alu_c  output  2  registered shift amount to ALU.
- alu_ans  input  4  ALU result.

Behaviour:
- Reset (sync, at clk edge with reset=1):
  - state=IDLE.
  - gnt0/1, done0/1, busy, res0/1, alu_op/a/b/c = 0.
  - Counter = 0.
  - last_winner = ~FIRST_PRIO.
  - Reset overrides every other event in the same edge.
- FSM states: IDLE, EXEC.
- IDLE, no request: no change; gnt and done cleared.
- IDLE, at least one request at edge E0:
  - Winner w: the sole requester, or ~last_winner if both requested.
  - alu_* <= winner's op/a/b/c; gntw <= 1 (high for the cycle after E0 only).
  - cnt <= LAT-1; state <= EXEC; busy <= 1.
  - Loser's request is ignored; it stays pending on its own req.
- EXEC:
  - Requests are not sampled; gnt = 0; alu_* held stable.
  - cnt != 0: cnt decrements.
  - cnt == 0 at edge:
    - resw <= alu_ans; donew <= 1 for one cycle.
    - last_winner <= w; state <= IDLE; busy <= 0.
- Latency: a request sampled at edge E0 gives its done pulse in the cycle after edge E0+LAT. With LAT=1, done is 2 cycles after the req edge.
- Back-to-back operation:
  - In the IDLE cycle where done is high, a new grant may be taken at the next edge.
  - Throughput is one op per LAT+1 cycles.
- Requester protocol:
  - Hold req and operands stable until gnt is seen.
  - Deassert req in the gnt cycle, or the same request is served again at the next IDLE edge.
  - Operands may change freely after gnt.
- Width rules:
  - All arithmetic is 4-bit modulo 16, done by the external ALU; no carry or overflow out.
  - The arbiter never alters alu_ans.
- Op encoding 2'bxx is passed through unchanged; the arbiter does not decode ops.
- Reset mid-EXEC: operation is abandoned, no done pulse, res0/1 cleared.
- Only one of gnt0/gnt1 is high in any cycle; same for done0/done1.

Test Plan:
- req0 with op=11, a0=3, b0=4, LAT=1:
  - gnt0 pulse one cycle after the req edge.
  - done0 one cycle later with res0=7; res1 unchanged at 0.
- req1 with op=00, a1=4'b1000, c1=2 -> done1 with res1=4'b1110.
- req1 with op=01, a1=4'b1000, c1=2 -> res1=4'b0010.
- req0 with op=10, a0=2, b0=5 -> res0=4'b1101 (wrap-around).
- req0 and req1 both held high for 4 ops, FIRST_PRIO=0:
  - Grant order 0,1,0,1.
  - Each requester drops req for one cycle after its gnt, then re-raises it.
  - busy low exactly one cycle between operations.
- LAT=3, req0 op=11 a0=15 b0=1:
  - busy high for 3 cycles.
  - done0 four cycles after the req edge with res0=0.
  - alu_a stays 15 throughout EXEC.
- Reset asserted on the second EXEC cycle (LAT=3):
  - No done pulse; all outputs 0 next cycle.
  - A subsequent tie is granted to requester FIRST_PRIO.
